// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping bus controller.
// Request encodings, FSM states and default line geometry.
package mesi_bus_pkg;

   localparam int DEF_TAG_W   = 17;
   localparam int DEF_INDEX_W = 10;
   localparam int DEF_LINE_W  = 256;

   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RDX  = 2'd1,
      BUS_UPGR = 2'd2
   } bus_req_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNOOP,
      S_RESP,
      S_WB,
      S_MEM,
      S_DONE
   } bus_state_e;

   typedef struct packed {
      logic [DEF_TAG_W-1:0]   tag;
      logic [DEF_INDEX_W-1:0] index;
   } line_addr_t;

endpackage

// File: rtl/mesi_snoop_bus_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   logic found;

   function automatic logic [PW-1:0] wrap(
      input logic [PW-1:0] p,
      input int            i
   );
      int k;
      k = int'(p) + i;
      if (k >= N) k = k - N;
      return PW'(k);
   endfunction

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[wrap(ptr, i)]) begin
            found                 = 1'b1;
            idx                   = wrap(ptr, i);
            grant[wrap(ptr, i)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mesi_snoop_bus.sv
// Snooping bus controller: arbitrates cache requests, broadcasts snoops,
// sources lines from a dirty owner (with write-back) or from memory.
module mesi_snoop_bus
   import mesi_bus_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int INDEX_W   = DEF_INDEX_W,
   parameter int LINE_W    = DEF_LINE_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_CORES-1:0]                req_i,
   input  logic [NUM_CORES-1:0][1:0]           req_type_i,
   input  logic [NUM_CORES-1:0][TAG_W-1:0]     req_tag_i,
   input  logic [NUM_CORES-1:0][INDEX_W-1:0]   req_index_i,
   output logic [NUM_CORES-1:0]                trans_en_o,
   output logic [NUM_CORES-1:0]                grant_o,
   output logic                                snoop_valid_o,
   output logic [1:0]                          snoop_type_o,
   output logic [TAG_W-1:0]                    snoop_tag_o,
   output logic [INDEX_W-1:0]                  snoop_index_o,
   output logic [NUM_CORES-1:0]                snoop_src_o,
   input  logic [NUM_CORES-1:0]                snoop_hit_i,
   input  logic [NUM_CORES-1:0]                snoop_dirty_i,
   input  logic [NUM_CORES-1:0][LINE_W-1:0]    snoop_line_i,
   output logic                                mem_rd_req_o,
   output logic                                mem_wr_req_o,
   output logic [TAG_W+INDEX_W-1:0]            mem_addr_o,
   output logic [LINE_W-1:0]                   mem_wr_line_o,
   input  logic                                mem_rd_valid_i,
   input  logic [LINE_W-1:0]                   mem_line_i,
   input  logic                                mem_wr_ack_i,
   output logic [NUM_CORES-1:0]                done_o,
   output logic [LINE_W-1:0]                   line_o,
   output logic                                shared_o
);

   localparam int PW = $clog2(NUM_CORES);

   bus_state_e state_q, state_d;

   logic [NUM_CORES-1:0] grant_q;
   logic [NUM_CORES-1:0] arb_gnt;
   logic [NUM_CORES-1:0] hit_m;
   logic [NUM_CORES-1:0] dirty_m;
   logic [PW-1:0]        ptr_q;
   logic [PW-1:0]        win_q;
   logic [PW-1:0]        arb_idx;
   logic [PW-1:0]        dirty_idx;
   logic [1:0]           type_q;
   logic [TAG_W-1:0]     tag_q;
   logic [INDEX_W-1:0]   index_q;
   logic [LINE_W-1:0]    line_q;
   logic                 shared_q;
   logic                 is_upgr;

   rr_arbiter #(
      .N  (NUM_CORES),
      .PW (PW)
   ) u_arb (
      .req   (req_i),
      .ptr   (ptr_q),
      .grant (arb_gnt),
      .idx   (arb_idx)
   );

   assign is_upgr = (type_q == BUS_UPGR);

   // The requester's own snoop reply describes its stale copy; drop it.
   assign hit_m   = snoop_hit_i & ~grant_q;
   assign dirty_m = snoop_dirty_i & ~grant_q;

   always_comb begin
      dirty_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (dirty_m[i]) dirty_idx = PW'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (|req_i) state_d = S_SNOOP;
         S_SNOOP: state_d = S_RESP;
         S_RESP: begin
            if (is_upgr)       state_d = S_DONE;
            else if (|dirty_m) state_d = S_WB;
            else               state_d = S_MEM;
         end
         S_WB:    if (mem_wr_ack_i) state_d = S_DONE;
         S_MEM:   if (mem_rd_valid_i) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q  <= '0;
         ptr_q    <= '0;
         win_q    <= '0;
         type_q   <= '0;
         tag_q    <= '0;
         index_q  <= '0;
         line_q   <= '0;
         shared_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (|req_i) begin
                  grant_q  <= arb_gnt;
                  win_q    <= arb_idx;
                  type_q   <= req_type_i[arb_idx];
                  tag_q    <= req_tag_i[arb_idx];
                  index_q  <= req_index_i[arb_idx];
                  line_q   <= '0;
                  shared_q <= 1'b0;
               end
            end
            S_RESP: begin
               shared_q <= |hit_m;
               if (!is_upgr && |dirty_m) begin
                  line_q <= snoop_line_i[dirty_idx];
               end
            end
            S_MEM: begin
               if (mem_rd_valid_i) line_q <= mem_line_i;
            end
            S_DONE: begin
               grant_q <= '0;
               ptr_q   <= (win_q == PW'(NUM_CORES - 1))
                          ? '0 : win_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign trans_en_o    = {NUM_CORES{state_q == S_IDLE}};
   assign grant_o       = grant_q;
   assign snoop_valid_o = (state_q == S_SNOOP);
   assign snoop_type_o  = snoop_valid_o ? type_q : '0;
   assign snoop_tag_o   = snoop_valid_o ? tag_q : '0;
   assign snoop_index_o = snoop_valid_o ? index_q : '0;
   assign snoop_src_o   = snoop_valid_o ? grant_q : '0;

   assign mem_rd_req_o  = (state_q == S_MEM);
   assign mem_wr_req_o  = (state_q == S_WB);
   assign mem_addr_o    = (mem_rd_req_o || mem_wr_req_o)
                          ? {tag_q, index_q} : '0;
   assign mem_wr_line_o = mem_wr_req_o ? line_q : '0;

   // Exclusive readers force every other copy to Invalid.
   assign done_o   = (state_q == S_DONE) ? grant_q : '0;
   assign line_o   = (state_q == S_DONE) ? line_q : '0;
   assign shared_o = (state_q == S_DONE) && shared_q
                     && (type_q != BUS_RDX);

`ifndef SYNTHESIS
   a_single_dirty: assert property (
      @(posedge clk) disable iff (!rst)
      (state_q == S_RESP) |-> $onehot0(dirty_m)
   );
`endif

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Scenario bench for mesi_snoop_bus with an expected-completion queue.
module tb_mesi_snoop_bus;

   localparam int N  = 4;
   localparam int TW = 17;
   localparam int IW = 10;
   localparam int LW = 256;
   localparam int MAXC = 60;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]           req_i = '0;
   logic [N-1:0][1:0]      req_type_i = '0;
   logic [N-1:0][TW-1:0]   req_tag_i = '0;
   logic [N-1:0][IW-1:0]   req_index_i = '0;
   logic [N-1:0]           trans_en_o, grant_o, snoop_src_o, done_o;
   logic                   snoop_valid_o, mem_rd_req_o, mem_wr_req_o;
   logic [1:0]             snoop_type_o;
   logic [TW-1:0]          snoop_tag_o;
   logic [IW-1:0]          snoop_index_o;
   logic [N-1:0]           snoop_hit_i = '0;
   logic [N-1:0]           snoop_dirty_i = '0;
   logic [N-1:0][LW-1:0]   snoop_line_i = '0;
   logic [TW+IW-1:0]       mem_addr_o;
   logic [LW-1:0]          mem_wr_line_o, line_o;
   logic                   mem_rd_valid_i = 1'b0;
   logic [LW-1:0]          mem_line_i = '0;
   logic                   mem_wr_ack_i = 1'b0;
   logic                   shared_o;

   mesi_snoop_bus #(
      .NUM_CORES (N), .TAG_W (TW), .INDEX_W (IW), .LINE_W (LW)
   ) dut (
      .clk (clk), .rst (rst),
      .req_i (req_i), .req_type_i (req_type_i),
      .req_tag_i (req_tag_i), .req_index_i (req_index_i),
      .trans_en_o (trans_en_o), .grant_o (grant_o),
      .snoop_valid_o (snoop_valid_o), .snoop_type_o (snoop_type_o),
      .snoop_tag_o (snoop_tag_o), .snoop_index_o (snoop_index_o),
      .snoop_src_o (snoop_src_o), .snoop_hit_i (snoop_hit_i),
      .snoop_dirty_i (snoop_dirty_i), .snoop_line_i (snoop_line_i),
      .mem_rd_req_o (mem_rd_req_o), .mem_wr_req_o (mem_wr_req_o),
      .mem_addr_o (mem_addr_o), .mem_wr_line_o (mem_wr_line_o),
      .mem_rd_valid_i (mem_rd_valid_i), .mem_line_i (mem_line_i),
      .mem_wr_ack_i (mem_wr_ack_i), .done_o (done_o),
      .line_o (line_o), .shared_o (shared_o)
   );

   typedef struct {
      logic [N-1:0]  done;
      logic [LW-1:0] line;
      logic          shared;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;

   logic [LW-1:0]    mem_data = {8{32'hA5A5_A5A5}};
   logic [LW-1:0]    dl = {16{16'h1234}};
   int               mem_lat = 2;
   int               wr_lat = 1;
   int               rd_cnt = 0;
   int               wr_cnt = 0;
   bit               rd_seen, wr_seen;
   logic [TW+IW-1:0] rd_addr, wr_addr;
   logic [LW-1:0]    wr_line;

   // Memory model: answers after mem_lat / wr_lat request cycles.
   initial begin
      forever begin
         @(negedge clk);
         mem_rd_valid_i = 1'b0;
         mem_wr_ack_i   = 1'b0;
         if (mem_rd_req_o) begin
            rd_seen = 1'b1;
            rd_addr = mem_addr_o;
            rd_cnt++;
            if (rd_cnt >= mem_lat) begin
               mem_rd_valid_i = 1'b1;
               mem_line_i     = mem_data;
               rd_cnt         = 0;
            end
         end else rd_cnt = 0;
         if (mem_wr_req_o) begin
            wr_seen = 1'b1;
            wr_addr = mem_addr_o;
            wr_line = mem_wr_line_o;
            wr_cnt++;
            if (wr_cnt >= wr_lat) begin
               mem_wr_ack_i = 1'b1;
               wr_cnt       = 0;
            end
         end else wr_cnt = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   logic [N-1:0]  o_d, o_g, o_src, o_te;
   logic [LW-1:0] o_l;
   logic          o_s;
   logic [1:0]    o_st;
   int            o_nc;
   bit            o_to;

   task automatic wait_done();
      bit got = 1'b0;
      o_nc = 0; o_g = '0; o_st = '0; o_src = '0;
      o_d = '0; o_l = '0; o_s = 1'b0; o_te = '1;
      while (!got && o_nc < MAXC) begin
         @(negedge clk);
         o_nc++;
         if (o_nc == 1) o_te = trans_en_o;
         if (o_g == '0 && grant_o != '0) o_g = grant_o;
         if (snoop_valid_o) begin
            o_st  = snoop_type_o;
            o_src = snoop_src_o;
         end
         if (done_o != '0) begin
            got = 1'b1;
            o_d = done_o; o_l = line_o; o_s = shared_o;
         end
      end
      o_to = !got;
   endtask

   task automatic issue(input int c, input logic [1:0] t,
                        input logic [TW-1:0] tg, input logic [IW-1:0] ix);
      req_type_i[c]  = t;
      req_tag_i[c]   = tg;
      req_index_i[c] = ix;
      req_i[c]       = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic score(input string nm);
      checks++;
      if (o_to) begin
         errors++;
         $display("FAIL %s timeout: no done_o within %0d cycles", nm, MAXC);
         return;
      end
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected done got=%b", nm, o_d);
         return;
      end
      e = exp_q.pop_front();
      if (o_d !== e.done) begin
         errors++;
         $display("FAIL %s done got=%b exp=%b", nm, o_d, e.done);
      end
      checks++;
      if (o_l !== e.line) begin
         errors++;
         $display("FAIL %s line got=%h exp=%h", nm, o_l, e.line);
      end
      checks++;
      if (o_s !== e.shared) begin
         errors++;
         $display("FAIL %s shared got=%b exp=%b", nm, o_s, e.shared);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (trans_en_o !== 4'hF) begin
         errors++;
         $display("FAIL reset trans_en got=%b exp=1111", trans_en_o);
      end
      checks++;
      if ({grant_o, done_o, snoop_valid_o, mem_rd_req_o, mem_wr_req_o,
           shared_o} !== '0 || line_o !== '0 || mem_addr_o !== '0) begin
         errors++;
         $display("FAIL reset outputs got grant=%b done=%b sv=%b rd=%b wr=%b exp=0",
                  grant_o, done_o, snoop_valid_o, mem_rd_req_o, mem_wr_req_o);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mem_read();
      rd_seen = 0; wr_seen = 0; mem_lat = 2;
      issue(1, 2'd0, 17'h1ABCD, 10'h2F3);
      exp_q.push_back('{4'b0010, mem_data, 1'b0});
      wait_done();
      req_i[1] = 1'b0;
      score("mem_read");
      checks++;
      if (o_nc !== 5) begin
         errors++;
         $display("FAIL mem_read latency got=%0d exp=5", o_nc);
      end
      checks++;
      if (rd_addr !== {17'h1ABCD, 10'h2F3}) begin
         errors++;
         $display("FAIL mem_read addr got=%h exp=%h", rd_addr,
                  {17'h1ABCD, 10'h2F3});
      end
      checks++;
      if (o_te !== 4'h0 || wr_seen !== 1'b0) begin
         errors++;
         $display("FAIL mem_read busy te got=%b wr=%b exp te=0000 wr=0",
                  o_te, wr_seen);
      end
      @(negedge clk);
      checks++;
      if (trans_en_o !== 4'hF || grant_o !== 4'h0) begin
         errors++;
         $display("FAIL mem_read idle te=%b grant=%b exp 1111/0000",
                  trans_en_o, grant_o);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] gx [4];
      gx[0] = 4'b0001; gx[1] = 4'b0100; gx[2] = 4'b1000; gx[3] = 4'b0001;
      do_reset();
      issue(0, 2'd0, 17'h00011, 10'h011);
      issue(2, 2'd0, 17'h00022, 10'h022);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{gx[k], mem_data, 1'b0});
         wait_done();
         if (k == 0) issue(3, 2'd0, 17'h00033, 10'h033);
         if (k == 1) req_i[2] = 1'b0;
         if (k == 2) req_i[3] = 1'b0;
         if (k == 3) req_i[0] = 1'b0;
         score("round_robin");
         checks++;
         if (o_g !== gx[k]) begin
            errors++;
            $display("FAIL round_robin grant%0d got=%b exp=%b", k, o_g, gx[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_writeback();
      rd_seen = 0; wr_seen = 0;
      snoop_hit_i = 4'b1000; snoop_dirty_i = 4'b1000;
      snoop_line_i[3] = dl;
      issue(0, 2'd0, 17'h0F0F0, 10'h155);
      exp_q.push_back('{4'b0001, dl, 1'b1});
      wait_done();
      req_i[0] = 1'b0;
      score("writeback");
      checks++;
      if (wr_seen !== 1'b1 || wr_line !== dl) begin
         errors++;
         $display("FAIL writeback wr seen=%b line=%h exp 1/%h", wr_seen, wr_line, dl);
      end
      checks++;
      if (wr_addr !== {17'h0F0F0, 10'h155}) begin
         errors++;
         $display("FAIL writeback addr got=%h exp=%h", wr_addr,
                  {17'h0F0F0, 10'h155});
      end
      checks++;
      if (rd_seen !== 1'b0 || o_nc !== 4) begin
         errors++;
         $display("FAIL writeback rd_seen=%b lat=%0d exp 0/4", rd_seen, o_nc);
      end
      snoop_hit_i = '0; snoop_dirty_i = '0; snoop_line_i = '0;
      @(negedge clk);
   endtask

   task automatic test_upgrade();
      rd_seen = 0; wr_seen = 0;
      snoop_hit_i = 4'b0010;
      snoop_line_i[1] = dl;
      issue(2, 2'd2, 17'h13579, 10'h0AA);
      exp_q.push_back('{4'b0100, '0, 1'b1});
      wait_done();
      req_i[2] = 1'b0;
      score("upgrade");
      checks++;
      if (o_st !== 2'd2 || o_src !== 4'b0100) begin
         errors++;
         $display("FAIL upgrade snoop type=%0d src=%b exp 2/0100", o_st, o_src);
      end
      checks++;
      if (o_nc !== 3) begin
         errors++;
         $display("FAIL upgrade latency got=%0d exp=3", o_nc);
      end
      checks++;
      if (rd_seen !== 1'b0 || wr_seen !== 1'b0) begin
         errors++;
         $display("FAIL upgrade mem rd=%b wr=%b exp 0/0", rd_seen, wr_seen);
      end
      snoop_hit_i = '0; snoop_line_i = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      rd_seen = 0; mem_lat = 20;
      issue(1, 2'd0, 17'h02468, 10'h3C3);
      exp_q.push_back('{4'b0010, mem_data, 1'b0});
      while (!mem_rd_req_o && n < MAXC) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_rd_req_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid mem_rd_req got=%b exp=1", mem_rd_req_o);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (trans_en_o !== 4'hF || grant_o !== '0 || mem_rd_req_o !== 1'b0
          || mem_addr_o !== '0) begin
         errors++;
         $display("FAIL reset_mid clear te=%b grant=%b rd=%b exp 1111/0000/0",
                  trans_en_o, grant_o, mem_rd_req_o);
      end
      void'(exp_q.pop_front());
      mem_lat = 2;
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back('{4'b0010, mem_data, 1'b0});
      wait_done();
      req_i[1] = 1'b0;
      score("reset_mid");
      @(negedge clk);
   endtask

   task automatic test_rdx_mask();
      rd_seen = 0; wr_seen = 0;
      snoop_hit_i = 4'b0010; snoop_dirty_i = 4'b0010;
      snoop_line_i[1] = dl;
      issue(1, 2'd1, 17'h1FFFF, 10'h001);
      exp_q.push_back('{4'b0010, mem_data, 1'b0});
      wait_done();
      req_i[1] = 1'b0;
      score("rdx_mask");
      checks++;
      if (rd_seen !== 1'b1 || wr_seen !== 1'b0) begin
         errors++;
         $display("FAIL rdx_mask path rd=%b wr=%b exp 1/0", rd_seen, wr_seen);
      end
      snoop_hit_i = '0; snoop_dirty_i = '0; snoop_line_i = '0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      issue(0, 2'd0, 17'h00100, 10'h100);
      issue(1, 2'd0, 17'h00200, 10'h200);
      exp_q.push_back('{4'b0001, mem_data, 1'b0});
      exp_q.push_back('{4'b0010, mem_data, 1'b0});
      wait_done();
      req_i[0] = 1'b0;
      score("b2b_first");
      wait_done();
      req_i[1] = 1'b0;
      score("b2b_second");
      checks++;
      if (o_nc !== 6 || o_te !== 4'hF) begin
         errors++;
         $display("FAIL b2b gap lat=%0d te=%b exp 6/1111", o_nc, o_te);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b leftover got=%0d exp=0", exp_q.size());
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_round_robin();
      test_writeback();
      test_upgrade();
      test_reset_mid();
      test_rdx_mask();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
